// File: rtl/towers_field_manager_if.sv
// Bus bundle between the frame/pixel timing side and the tower field manager.
// The master drives frame, pixel, spawn and control requests; the slave
// answers with the per-pixel drawing result and the field status.
interface towers_field_manager_if;
    logic               startOfFrame;
    logic        [10:0] pixelX;
    logic        [10:0] pixelY;
    logic signed [10:0] spawnX;
    logic               pause;
    logic               levelUp;
    logic               hitClearValid;
    logic        [4:0]  hitClearIdx;
    logic               drawingRequest;
    logic        [10:0] offsetX;
    logic        [10:0] offsetY;
    logic        [4:0]  hitSlot;
    logic        [5:0]  activeCount;
    logic               spawnDropped;

    modport master (
        output startOfFrame, pixelX, pixelY, spawnX, pause, levelUp,
               hitClearValid, hitClearIdx,
        input  drawingRequest, offsetX, offsetY, hitSlot, activeCount,
               spawnDropped
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, spawnX, pause, levelUp,
               hitClearValid, hitClearIdx,
        output drawingRequest, offsetX, offsetY, hitSlot, activeCount,
               spawnDropped
    );
endinterface

// File: rtl/towers_field_manager.sv
// Multi-slot falling tower manager: spawns towers on a frame timer into the
// lowest free slot, drops them with a fixed-point speed each frame, retires
// them at the screen bottom or on an external hit, ramps difficulty on
// levelUp, and resolves which tower (lowest slot wins) covers the pixel.
module towers_field_manager #(
    parameter int NUM_SLOTS      = 10,
    parameter int OBJECT_WIDTH_X = 28,
    parameter int OBJECT_HEIGHT_Y = 58,
    parameter int FP_SHIFT       = 6,
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int BASE_SPEED     = 100,
    parameter int SPEED_STEP     = 16,
    parameter int MAX_SPEED      = 400,
    parameter int SPAWN_WAIT     = 100,
    parameter int WAIT_STEP      = 10,
    parameter int MIN_SPAWN_WAIT = 30
) (
    input logic                   clk,
    input logic                   resetN,
    towers_field_manager_if.slave bus
);

    // Integer positions are 12 bits; comparisons use 13 bits so that
    // position plus object size can never wrap.
    localparam int POS_W = 12;
    localparam int FP_W  = POS_W + FP_SHIFT;
    localparam int CMP_W = 13;
    localparam int MAX_X = SCREEN_WIDTH - OBJECT_WIDTH_X;

    logic [NUM_SLOTS-1:0] r_active;
    logic [FP_W-1:0]      r_xFp [NUM_SLOTS];
    logic [FP_W-1:0]      r_yFp [NUM_SLOTS];
    logic [15:0]          r_speed;
    logic [15:0]          r_spawnWait;
    logic [15:0]          r_timer;
    logic                 r_spawnDropped;
    logic [5:0]           r_activeCount;
    logic                 r_drawingRequest;
    logic [10:0]          r_offsetX;
    logic [10:0]          r_offsetY;
    logic [4:0]           r_hitSlot;

    logic [CMP_W-1:0]     w_xPos [NUM_SLOTS];
    logic [CMP_W-1:0]     w_yPos [NUM_SLOTS];
    logic [CMP_W-1:0]     w_pixX;
    logic [CMP_W-1:0]     w_pixY;
    logic [NUM_SLOTS-1:0] w_pixHit;
    logic                 w_drawing;
    logic [10:0]          w_offX;
    logic [10:0]          w_offY;
    logic [4:0]           w_hitIdx;

    logic                 w_frameTick;
    logic                 w_spawnDue;
    logic                 w_clearValid;
    logic                 w_haveFree;
    logic [NUM_SLOTS-1:0] w_clearMask;
    logic [NUM_SLOTS-1:0] w_freeMask;
    logic [NUM_SLOTS-1:0] w_spawnMask;
    logic [10:0]          w_clampX;
    logic [5:0]           w_count;
    logic [16:0]          w_speedSum;

    assign w_pixX = CMP_W'(bus.pixelX);
    assign w_pixY = CMP_W'(bus.pixelY);

    // Integer tower positions and per-slot pixel coverage.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_xPos[s]   = CMP_W'(r_xFp[s] >> FP_SHIFT);
            w_yPos[s]   = CMP_W'(r_yFp[s] >> FP_SHIFT);
            w_pixHit[s] = r_active[s]
                       && (w_pixX >= w_xPos[s])
                       && (w_pixX <  w_xPos[s] + CMP_W'(OBJECT_WIDTH_X))
                       && (w_pixY >= w_yPos[s])
                       && (w_pixY <  w_yPos[s] + CMP_W'(OBJECT_HEIGHT_Y));
        end
    end

    // Pick the lowest covering slot by scanning from the top index down.
    always_comb begin
        w_drawing = 1'b0;
        w_offX    = '0;
        w_offY    = '0;
        w_hitIdx  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (w_pixHit[s]) begin
                w_drawing = 1'b1;
                w_offX    = 11'(w_pixX - w_xPos[s]);
                w_offY    = 11'(w_pixY - w_yPos[s]);
                w_hitIdx  = 5'(s);
            end
        end
    end

    assign w_frameTick  = bus.startOfFrame && !bus.pause;
    assign w_spawnDue   = w_frameTick && (r_timer == 16'd0);
    assign w_clearValid = bus.hitClearValid
                       && ({27'd0, bus.hitClearIdx} < 32'(NUM_SLOTS));

    // Decode the hit-clear request into a one-hot slot mask.
    always_comb begin
        w_clearMask = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_clearMask[s] = w_clearValid && (bus.hitClearIdx == 5'(s));
        end
    end

    // A slot is spawnable only if it was empty before this edge and is not
    // being cleared; x & -x isolates the lowest such slot.
    assign w_freeMask  = ~r_active & ~w_clearMask;
    assign w_haveFree  = |w_freeMask;
    assign w_spawnMask = w_spawnDue
                       ? (w_freeMask & (~w_freeMask + NUM_SLOTS'(1)))
                       : '0;

    // Clamp the requested spawn column onto the visible area.
    always_comb begin
        w_clampX = $unsigned(bus.spawnX);
        if (bus.spawnX < 0) begin
            w_clampX = '0;
        end else if (int'(bus.spawnX) > MAX_X) begin
            w_clampX = 11'(MAX_X);
        end
    end

    // Population count of the active flags.
    always_comb begin
        w_count = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_count = w_count + 6'(r_active[s]);
        end
    end

    assign w_speedSum = {1'b0, r_speed} + 17'(SPEED_STEP);

    // Per-slot life cycle: a clear beats everything, live towers fall or
    // retire at the bottom, and the chosen free slot takes the new tower.
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_active <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                r_xFp[s] <= '0;
                r_yFp[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_clearMask[s]) begin
                    r_active[s] <= 1'b0;
                end else if (w_frameTick && r_active[s]) begin
                    if (w_yPos[s] >= CMP_W'(SCREEN_HEIGHT)) begin
                        r_active[s] <= 1'b0;
                    end else begin
                        r_yFp[s] <= r_yFp[s] + FP_W'(r_speed);
                    end
                end else if (w_spawnMask[s]) begin
                    r_active[s] <= 1'b1;
                    r_yFp[s]    <= '0;
                    r_xFp[s]    <= FP_W'(w_clampX) << FP_SHIFT;
                end
            end
        end
    end

    // Spawn timer and difficulty ramp; a new level is only seen by later frames.
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_speed        <= 16'(BASE_SPEED);
            r_spawnWait    <= 16'(SPAWN_WAIT);
            r_timer        <= 16'(SPAWN_WAIT);
            r_spawnDropped <= 1'b0;
        end else begin
            r_spawnDropped <= w_spawnDue && !w_haveFree;
            if (w_frameTick) begin
                r_timer <= (r_timer != 16'd0) ? r_timer - 16'd1 : r_spawnWait;
            end
            if (bus.levelUp) begin
                r_speed <= (w_speedSum > 17'(MAX_SPEED))
                         ? 16'(MAX_SPEED) : w_speedSum[15:0];
                r_spawnWait <= (r_spawnWait >= 16'(MIN_SPAWN_WAIT + WAIT_STEP))
                             ? r_spawnWait - 16'(WAIT_STEP)
                             : 16'(MIN_SPAWN_WAIT);
            end
        end
    end

    // Registered pixel result and field status.
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_drawingRequest <= 1'b0;
            r_offsetX        <= '0;
            r_offsetY        <= '0;
            r_hitSlot        <= '0;
            r_activeCount    <= '0;
        end else begin
            r_drawingRequest <= w_drawing;
            r_offsetX        <= w_offX;
            r_offsetY        <= w_offY;
            r_hitSlot        <= w_hitIdx;
            r_activeCount    <= w_count;
        end
    end

    assign bus.drawingRequest = r_drawingRequest;
    assign bus.offsetX        = r_offsetX;
    assign bus.offsetY        = r_offsetY;
    assign bus.hitSlot        = r_hitSlot;
    assign bus.activeCount    = r_activeCount;
    assign bus.spawnDropped   = r_spawnDropped;

endmodule

// File: tb/tb_towers_field_manager.sv
// Bench for towers_field_manager: a 10-slot instance and a 2-slot, fast-spawn
// instance share one stimulus stream and are compared against a frame-level
// model of the tower field.
module tb_towers_field_manager;

    localparam int W    = 28;
    localparam int H    = 58;
    localparam int SH   = 6;
    localparam int MAXX = 612;

    logic clk = 1'b0;
    logic resetN;

    // Free-running system clock.
    always #5 clk = ~clk;

    towers_field_manager_if busA ();
    towers_field_manager_if busB ();

    towers_field_manager dutA (
        .clk    (clk),
        .resetN (resetN),
        .bus    (busA)
    );

    towers_field_manager #(
        .NUM_SLOTS      (2),
        .SPAWN_WAIT     (20),
        .MIN_SPAWN_WAIT (5)
    ) dutB (
        .clk    (clk),
        .resetN (resetN),
        .bus    (busB)
    );

    int checks = 0;
    int errors = 0;

    int mNum      [2] = '{10, 2};
    int mWaitInit [2] = '{100, 20};
    int mMinWait  [2] = '{30, 5};
    int mActive   [2][32];
    int mX        [2][32];
    int mY        [2][32];
    int mSpeed    [2];
    int mWait     [2];
    int mTimer    [2];
    int expDrop   [2];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mSpeed[d]  = 100;
            mWait[d]   = mWaitInit[d];
            mTimer[d]  = mWaitInit[d];
            expDrop[d] = 0;
            for (int s = 0; s < 32; s++) begin
                mActive[d][s] = 0;
                mX[d][s]      = 0;
                mY[d][s]      = 0;
            end
        end
    endtask

    // One clock of the field as the rules describe it.
    task automatic modelCycle(input int d, input bit sof, input bit pse, input bit lvl,
                              input bit hcv, input int hci, input int sx);
        int  was [32];
        int  cl;
        int  xc;
        bit  placed;
        cl = (hcv && hci < mNum[d]) ? hci : -1;
        for (int s = 0; s < 32; s++) was[s] = mActive[d][s];
        expDrop[d] = 0;
        if (cl >= 0) mActive[d][cl] = 0;
        if (sof && !pse) begin
            for (int s = 0; s < mNum[d]; s++) begin
                if (was[s] != 0 && s != cl) begin
                    if ((mY[d][s] >> SH) >= 480) mActive[d][s] = 0;
                    else mY[d][s] = mY[d][s] + mSpeed[d];
                end
            end
            if (mTimer[d] > 0) begin
                mTimer[d] = mTimer[d] - 1;
            end else begin
                mTimer[d] = mWait[d];
                xc = (sx < 0) ? 0 : ((sx > MAXX) ? MAXX : sx);
                placed = 0;
                for (int s = 0; s < mNum[d]; s++) begin
                    if (!placed && was[s] == 0 && s != cl) begin
                        mActive[d][s] = 1;
                        mY[d][s]      = 0;
                        mX[d][s]      = xc * 64;
                        placed        = 1;
                    end
                end
                if (!placed) expDrop[d] = 1;
            end
        end
        if (lvl) begin
            mSpeed[d] = (mSpeed[d] + 16 > 400) ? 400 : mSpeed[d] + 16;
            mWait[d]  = (mWait[d] - 10 < mMinWait[d]) ? mMinWait[d] : mWait[d] - 10;
        end
    endtask

    task automatic modelPixel(input int d, input int px, input int py,
                              output int draw, output int ox, output int oy, output int hs);
        int x;
        int y;
        draw = 0; ox = 0; oy = 0; hs = 0;
        for (int s = 0; s < mNum[d]; s++) begin
            x = mX[d][s] / 64;
            y = mY[d][s] / 64;
            if (draw == 0 && mActive[d][s] != 0 && px >= x && px < x + W && py >= y && py < y + H) begin
                draw = 1; ox = px - x; oy = py - y; hs = s;
            end
        end
    endtask

    function automatic int modelCount(input int d);
        int n = 0;
        for (int s = 0; s < 32; s++) n += mActive[d][s];
        return n;
    endfunction

    task automatic applyStimulus(input bit sof, input bit pse, input bit lvl,
                                 input bit hcv, input int hci, input int sx);
        busA.startOfFrame = sof;  busB.startOfFrame = sof;
        busA.pause = pse;         busB.pause = pse;
        busA.levelUp = lvl;       busB.levelUp = lvl;
        busA.hitClearValid = hcv; busB.hitClearValid = hcv;
        busA.hitClearIdx = 5'(hci);
        busB.hitClearIdx = 5'(hci);
        busA.spawnX = 11'(sx);
        busB.spawnX = 11'(sx);
        modelCycle(0, sof, pse, lvl, hcv, hci, sx);
        modelCycle(1, sof, pse, lvl, hcv, hci, sx);
        tick();
        busA.startOfFrame = 1'b0; busB.startOfFrame = 1'b0;
        busA.levelUp = 1'b0;      busB.levelUp = 1'b0;
        busA.hitClearValid = 1'b0; busB.hitClearValid = 1'b0;
        checkOutput("dropA", int'(busA.spawnDropped), expDrop[0]);
        checkOutput("dropB", int'(busB.spawnDropped), expDrop[1]);
        tick();
        checkOutput("countA", int'(busA.activeCount), modelCount(0));
        checkOutput("countB", int'(busB.activeCount), modelCount(1));
        checkOutput("dropEndA", int'(busA.spawnDropped), 0);
        checkOutput("dropEndB", int'(busB.spawnDropped), 0);
    endtask

    task automatic runFrames(input int n, input int sx);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, sx);
    endtask

    task automatic probe(input int px, input int py);
        int draw, ox, oy, hs;
        busA.pixelX = 11'(px); busA.pixelY = 11'(py);
        busB.pixelX = 11'(px); busB.pixelY = 11'(py);
        tick();
        modelPixel(0, px, py, draw, ox, oy, hs);
        checkOutput("drawA", int'(busA.drawingRequest), draw);
        checkOutput("offXA", int'(busA.offsetX), ox);
        checkOutput("offYA", int'(busA.offsetY), oy);
        checkOutput("slotA", int'(busA.hitSlot), hs);
        modelPixel(1, px, py, draw, ox, oy, hs);
        checkOutput("drawB", int'(busB.drawingRequest), draw);
        checkOutput("offXB", int'(busB.offsetX), ox);
        checkOutput("offYB", int'(busB.offsetY), oy);
        checkOutput("slotB", int'(busB.hitSlot), hs);
    endtask

    task automatic probeAround(input int d);
        int cand [$];
        int s, px, py;
        for (int k = 0; k < mNum[d]; k++) if (mActive[d][k] != 0) cand.push_back(k);
        if (cand.size() == 0) begin
            probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end else begin
            s  = cand[$urandom_range(0, cand.size() - 1)];
            px = mX[d][s] / 64 + int'($urandom_range(0, W + 3)) - 2;
            py = mY[d][s] / 64 + int'($urandom_range(0, H + 3)) - 2;
            probe((px < 0) ? 0 : px, (py < 0) ? 0 : py);
        end
    endtask

    // Directed walk through the field's key situations, then random traffic.
    initial begin
        busA.startOfFrame = 1'b0; busB.startOfFrame = 1'b0;
        busA.pixelX = '0; busA.pixelY = '0; busB.pixelX = '0; busB.pixelY = '0;
        busA.spawnX = '0; busB.spawnX = '0;
        busA.pause = 1'b0; busB.pause = 1'b0;
        busA.levelUp = 1'b0; busB.levelUp = 1'b0;
        busA.hitClearValid = 1'b0; busB.hitClearValid = 1'b0;
        busA.hitClearIdx = '0; busB.hitClearIdx = '0;
        resetN = 1'b1;
        tick();
        tick();
        checkOutput("rstCountA", int'(busA.activeCount), 0);
        checkOutput("rstDrawA", int'(busA.drawingRequest), 0);
        checkOutput("rstDropA", int'(busA.spawnDropped), 0);
        checkOutput("rstOffXA", int'(busA.offsetX), 0);
        checkOutput("rstSlotB", int'(busB.hitSlot), 0);
        resetN = 1'b0;
        modelReset();
        tick();

        runFrames(42, 100);
        probe(105, 40);
        checkOutput("ovlpDrawB", int'(busB.drawingRequest), 1);
        checkOutput("ovlpSlotB", int'(busB.hitSlot), 0);
        checkOutput("ovlpOffXB", int'(busB.offsetX), 5);
        checkOutput("ovlpOffYB", int'(busB.offsetY), 8);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 100);
        probe(105, 40);
        checkOutput("clrDrawB", int'(busB.drawingRequest), 1);
        checkOutput("clrSlotB", int'(busB.hitSlot), 1);
        checkOutput("clrOffYB", int'(busB.offsetY), 39);

        runFrames(58, 100);
        checkOutput("spawn101A", int'(busA.activeCount), 1);
        probe(100, 0);
        checkOutput("firstDrawA", int'(busA.drawingRequest), 1);
        checkOutput("firstSlotA", int'(busA.hitSlot), 0);
        checkOutput("firstOffXA", int'(busA.offsetX), 0);
        probe(99, 0);
        checkOutput("leftEdgeA", int'(busA.drawingRequest), 0);

        runFrames(64, 100);
        probe(100, 100);
        checkOutput("fallDrawA", int'(busA.drawingRequest), 1);
        checkOutput("fallOffYA", int'(busA.offsetY), 0);
        probe(128, 100);
        checkOutput("rightEdgeA", int'(busA.drawingRequest), 0);
        probe(127, 157);
        checkOutput("cornerOffXA", int'(busA.offsetX), 27);
        checkOutput("cornerOffYA", int'(busA.offsetY), 57);

        runFrames(37, -5);
        probe(0, 0);
        checkOutput("clampLoSlotA", int'(busA.hitSlot), 1);
        checkOutput("clampLoDrawA", int'(busA.drawingRequest), 1);
        runFrames(101, 700);
        probe(612, 0);
        checkOutput("clampHiSlotA", int'(busA.hitSlot), 2);
        checkOutput("clampHiOffXA", int'(busA.offsetX), 0);
        probe(611, 0);
        checkOutput("clampHiEdgeA", int'(busA.drawingRequest), 0);

        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 300);
            probeAround(0);
            probeAround(1);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 50);
            probeAround(0);
            probeAround(1);
        end

        for (int i = 0; i < 300; i++) begin
            int sx;
            int hci;
            sx  = int'($urandom_range(0, 800)) - 60;
            hci = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 11));
            applyStimulus(1'b1, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 11) == 0, hci, sx);
            if ($urandom_range(0, 14) == 0)
                applyStimulus(1'b0, 1'b0, 1'b1, $urandom_range(0, 3) == 0, hci, sx);
            probeAround(0);
            probeAround(1);
            probe(int'($urandom_range(0, 700)), int'($urandom_range(0, 560)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
